// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the MEM-stage load/store controller.
package mem_pkg;

  localparam int DATA_W = 32;
  localparam logic [31:0] MEM_BASE_ADDR = 32'h1000_1000;
  localparam int unsigned MEM_DEPTH_WORDS = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  // The reserved size encoding is reported as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data_memory port bundle of the MEM-stage controller.
interface mem_access_unit_if import mem_pkg::*; ();

  logic              req;
  logic              is_store;
  logic [1:0]        size;
  logic              is_unsigned;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] store_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] load_data;
  logic              err_misalign;
  logic              err_range;
  logic [DATA_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_write_data;
  logic              dm_mem_read;
  logic              dm_mem_write;
  logic [DATA_W-1:0] dm_read_data;

  modport master (
    output req, is_store, size, is_unsigned, addr, store_data, dm_read_data,
    input  busy, done, load_data, err_misalign, err_range,
           dm_address, dm_write_data, dm_mem_read, dm_mem_write
  );

  modport slave (
    input  req, is_store, size, is_unsigned, addr, store_data, dm_read_data,
    output busy, done, load_data, err_misalign, err_range,
           dm_address, dm_write_data, dm_mem_read, dm_mem_write
  );

endinterface

// File: rtl/lane_align.sv
// Big-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lane_align import mem_pkg::*; (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] merged
);

  logic [4:0] byte_sh;
  logic [4:0] half_sh;

  // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
  assign byte_sh = {~offset, 3'b000};
  assign half_sh = {~offset[1], 4'b0000};

  function automatic logic [DATA_W-1:0] extend_byte(input logic [7:0] b, input logic uns);
    logic signed [7:0]        b_s;
    logic signed [DATA_W-1:0] wide_s;
    b_s    = b;
    wide_s = b_s;
    return uns ? {{(DATA_W-8){1'b0}}, b} : wide_s;
  endfunction

  function automatic logic [DATA_W-1:0] extend_half(input logic [15:0] h, input logic uns);
    logic signed [15:0]       h_s;
    logic signed [DATA_W-1:0] wide_s;
    h_s    = h;
    wide_s = h_s;
    return uns ? {{(DATA_W-16){1'b0}}, h} : wide_s;
  endfunction

  always_comb begin
    load_val = '0;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        load_val              = extend_byte(word[byte_sh +: 8], is_unsigned);
        merged[byte_sh +: 8]  = store_data[7:0];
      end
      SZ_HALF: begin
        load_val              = extend_half(word[half_sh +: 16], is_unsigned);
        merged[half_sh +: 16] = store_data[15:0];
      end
      SZ_WORD: begin
        load_val = word;
        merged   = store_data;
      end
      default: begin
        load_val = '0;
        merged   = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: one request at a time against a word-only
// data memory, with read-modify-write for byte and halfword stores.
module mem_access_unit import mem_pkg::*; #(
  parameter logic [31:0] BASE_ADDR   = MEM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = MEM_DEPTH_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);

  // 33-bit limit so a window ending at the top of the address space cannot wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  state_e            state;
  logic              r_is_store;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_off;
  logic [DATA_W-1:0] r_sdata;

  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] load_q;
  logic              mis_q;
  logic              rng_q;
  logic [DATA_W-1:0] dm_addr_q;
  logic [DATA_W-1:0] dm_wdata_q;
  logic              dm_rd_q;
  logic              dm_wr_q;

  logic              misalign_in;
  logic              range_in;
  logic [DATA_W-1:0] word_addr;
  logic [DATA_W-1:0] lane_load;
  logic [DATA_W-1:0] lane_merged;

  assign misalign_in = is_misaligned(bus.size, bus.addr[1:0]);
  assign range_in    = (bus.addr < BASE_ADDR) || ({1'b0, bus.addr} >= LIMIT);
  assign word_addr   = {bus.addr[31:2], 2'b00};

  lane_align u_lane_align (
    .word        (bus.dm_read_data),
    .offset      (r_off),
    .size        (r_size),
    .is_unsigned (r_uns),
    .store_data  (r_sdata),
    .load_val    (lane_load),
    .merged      (lane_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_is_store <= 1'b0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_off      <= '0;
      r_sdata    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_q     <= '0;
      mis_q      <= 1'b0;
      rng_q      <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_rd_q    <= 1'b0;
      dm_wr_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            r_is_store <= bus.is_store;
            r_size     <= bus.size;
            r_uns      <= bus.is_unsigned;
            r_off      <= bus.addr[1:0];
            r_sdata    <= bus.store_data;
            busy_q     <= 1'b1;
            if (misalign_in || range_in) begin
              state  <= RESP;
              done_q <= 1'b1;
              mis_q  <= misalign_in;
              rng_q  <= range_in;
            end else if (!bus.is_store || (bus.size != SZ_WORD)) begin
              state     <= RD;
              dm_rd_q   <= 1'b1;
              dm_addr_q <= word_addr;
            end else begin
              state      <= WR;
              dm_wr_q    <= 1'b1;
              dm_addr_q  <= word_addr;
              dm_wdata_q <= bus.store_data;
            end
          end
        end
        // dm_read_data is valid this cycle; loads finish, sub-word stores merge.
        RD: begin
          dm_rd_q <= 1'b0;
          if (r_is_store) begin
            state      <= WR;
            dm_wr_q    <= 1'b1;
            dm_wdata_q <= lane_merged;
          end else begin
            state     <= RESP;
            dm_addr_q <= '0;
            done_q    <= 1'b1;
            load_q    <= lane_load;
          end
        end
        WR: begin
          state      <= RESP;
          dm_wr_q    <= 1'b0;
          dm_addr_q  <= '0;
          dm_wdata_q <= '0;
          done_q     <= 1'b1;
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          load_q <= '0;
          mis_q  <= 1'b0;
          rng_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          dm_rd_q <= 1'b0;
          dm_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.load_data     = load_q;
  assign bus.err_misalign  = mis_q;
  assign bus.err_range     = rng_q;
  assign bus.dm_address    = dm_addr_q;
  assign bus.dm_write_data = dm_wdata_q;
  assign bus.dm_mem_read   = dm_rd_q;
  assign bus.dm_mem_write  = dm_wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-lane arithmetic reference model.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_1000;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && ({32'b0, a} < ({32'b0, BASE} + 64'(4 * DEPTH)));
  endfunction

  function automatic logic [3:0] widx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return d[5:2];
  endfunction

  // data_memory: combinational read, write at the clock edge
  always_comb begin
    bus.dm_read_data = '0;
    if (bus.dm_mem_read && in_win(bus.dm_address))
      bus.dm_read_data = mem[widx(bus.dm_address)];
  end

  always @(posedge clk)
    if (bus.dm_mem_write && in_win(bus.dm_address))
      mem[widx(bus.dm_address)] <= bus.dm_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: computes the outcome directly from the access rules, updating ref_mem.
  task automatic model(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] sd,
                       output int lat, output logic [31:0] ld, output logic mis,
                       output logic rng, output int nrd, output int nwr,
                       output logic [31:0] wword);
    logic [63:0] ua, w, v, mask;
    int nbytes, off, shift, idx;
    ua  = {32'b0, a};
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    rng = (ua < {32'b0, BASE}) || (ua >= {32'b0, BASE} + 64'(4 * DEPTH));
    ld = '0; wword = '0; nrd = 0; nwr = 0; lat = 1;
    if (!(mis || rng)) begin
      idx    = int'((ua - {32'b0, BASE}) / 4);
      off    = int'(ua % 4);
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      shift  = 8 * (4 - off - nbytes);
      mask   = (64'd1 << (8 * nbytes)) - 64'd1;
      w      = {32'b0, ref_mem[idx]};
      if (!st) begin
        v = (w >> shift) & mask;
        if (!uns && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 64'd1) == 64'd1)
          v = v | (64'hFFFF_FFFF & ~mask);
        ld  = v[31:0];
        lat = 2;
        nrd = 1;
      end else begin
        v            = (w & ~(mask << shift)) | (({32'b0, sd} & mask) << shift);
        wword        = v[31:0];
        ref_mem[idx] = wword;
        nwr          = 1;
        nrd          = (nbytes < 4) ? 1 : 0;
        lat          = (nbytes < 4) ? 3 : 2;
      end
    end
  endtask

  task automatic access(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] sd, input logic noise,
                        output logic [31:0] ld_o, output logic [31:0] wd_o);
    int e_lat, e_nrd, e_nwr, cyc, g, o_nrd, o_nwr, both, busy_low, addr_bad;
    logic [31:0] e_ld, e_wword, e_addr;
    logic e_mis, e_rng, got_done, o_mis, o_rng;
    model(st, sz, uns, a, sd, e_lat, e_ld, e_mis, e_rng, e_nrd, e_nwr, e_wword);
    e_addr = {a[31:2], 2'b00};
    g = 0;
    @(negedge clk);
    while (bus.busy && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("idle_before", 32'(bus.busy), 32'd0);
    check("done_pulse", 32'(bus.done), 32'd0);
    bus.is_store = st; bus.size = sz; bus.is_unsigned = uns;
    bus.addr = a; bus.store_data = sd; bus.req = 1'b1;
    cyc = 0; got_done = 1'b0; o_nrd = 0; o_nwr = 0; both = 0; busy_low = 0; addr_bad = 0;
    ld_o = '0; wd_o = '0; o_mis = 1'b0; o_rng = 1'b0;
    while (!got_done && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (noise) begin
        bus.req = 1'($urandom); bus.is_store = 1'($urandom); bus.size = 2'($urandom);
        bus.is_unsigned = 1'($urandom); bus.addr = $urandom; bus.store_data = $urandom;
      end else begin
        bus.req = 1'b0;
      end
      if (!bus.busy) busy_low++;
      if (bus.dm_mem_read) o_nrd++;
      if (bus.dm_mem_write) begin
        o_nwr++;
        wd_o = bus.dm_write_data;
      end
      if (bus.dm_mem_read && bus.dm_mem_write) both++;
      if ((bus.dm_mem_read || bus.dm_mem_write) && bus.dm_address != e_addr) addr_bad++;
      if (!bus.dm_mem_read && !bus.dm_mem_write && bus.dm_address != 32'd0) addr_bad++;
      if (bus.done) begin
        got_done = 1'b1;
        ld_o  = bus.load_data;
        o_mis = bus.err_misalign;
        o_rng = bus.err_range;
      end
    end
    bus.req = 1'b0;
    check("latency", 32'(cyc), 32'(e_lat));
    check("load_data", ld_o, e_ld);
    check("err_misalign", 32'(o_mis), 32'(e_mis));
    check("err_range", 32'(o_rng), 32'(e_rng));
    check("rd_strobes", 32'(o_nrd), 32'(e_nrd));
    check("wr_strobes", 32'(o_nwr), 32'(e_nwr));
    check("rd_wr_overlap", 32'(both), 32'd0);
    check("busy_low", 32'(busy_low), 32'd0);
    check("dm_address", 32'(addr_bad), 32'd0);
    if (e_nwr != 0) check("write_data", wd_o, e_wword);
    if (!(e_mis || e_rng)) check("mem_word", mem[widx(a)], ref_mem[widx(a)]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ld, wd, w;
    logic [8:0]  done_bits, busy_bits;
    logic [31:0] b_ld, b_wd;
    logic        b_mis, b_rng;
    int          b_lat, b_nrd, b_nwr, seen, r;
    logic [1:0]  sz;
    logic [31:0] a;

    rst_n = 1'b0;
    bus.req = 1'b0; bus.is_store = 1'b0; bus.size = '0; bus.is_unsigned = 1'b0;
    bus.addr = '0; bus.store_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      mem[i] <= w;
      ref_mem[i] = w;
    end
    mem[0] <= 32'h8000FF7F; ref_mem[0] = 32'h8000FF7F;
    mem[2] <= 32'h11223344; ref_mem[2] = 32'h11223344;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_load_data", bus.load_data, 32'd0);
    check("rst_errs", {30'd0, bus.err_misalign, bus.err_range}, 32'd0);
    check("rst_dm_address", bus.dm_address, 32'd0);
    check("rst_dm_write_data", bus.dm_write_data, 32'd0);
    check("rst_strobes", {30'd0, bus.dm_mem_read, bus.dm_mem_write}, 32'd0);
    rst_n = 1'b1;

    access(1'b1, SZ_WORD, 1'b0, 32'h10001004, 32'hDEADBEEF, 1'b0, ld, wd);
    check("sw_wdata", wd, 32'hDEADBEEF);
    access(1'b0, SZ_WORD, 1'b0, 32'h10001004, 32'h0, 1'b0, ld, wd);
    check("lw_value", ld, 32'hDEADBEEF);
    access(1'b1, SZ_BYTE, 1'b0, 32'h1000100A, 32'h000000AA, 1'b0, ld, wd);
    check("sb_merge", wd, 32'h1122AA44);
    access(1'b0, SZ_BYTE, 1'b1, 32'h1000100A, 32'h0, 1'b0, ld, wd);
    check("lbu_value", ld, 32'h000000AA);
    access(1'b0, SZ_HALF, 1'b0, 32'h10001000, 32'h0, 1'b0, ld, wd);
    check("lh_value", ld, 32'hFFFF8000);
    access(1'b0, SZ_HALF, 1'b1, 32'h10001000, 32'h0, 1'b0, ld, wd);
    check("lhu_value", ld, 32'h00008000);
    access(1'b0, SZ_BYTE, 1'b0, 32'h10001003, 32'h0, 1'b0, ld, wd);
    check("lb3_value", ld, 32'h0000007F);
    access(1'b0, SZ_BYTE, 1'b0, 32'h10001002, 32'h0, 1'b0, ld, wd);
    check("lb2_value", ld, 32'hFFFFFFFF);
    access(1'b0, SZ_WORD, 1'b0, 32'h10001002, 32'h0, 1'b0, ld, wd);
    access(1'b1, SZ_HALF, 1'b0, 32'h10001001, 32'h1234, 1'b0, ld, wd);
    access(1'b1, SZ_WORD, 1'b0, 32'h10001040, 32'h5555AAAA, 1'b0, ld, wd);
    access(1'b0, SZ_WORD, 1'b0, 32'h10000FFC, 32'h0, 1'b0, ld, wd);
    access(1'b0, 2'b11, 1'b0, 32'hFFFFFFFD, 32'h0, 1'b0, ld, wd);

    // Reset pulse during the write phase of a byte store
    @(negedge clk);
    bus.is_store = 1'b1; bus.size = SZ_BYTE; bus.is_unsigned = 1'b0;
    bus.addr = 32'h10001009; bus.store_data = 32'h000000EE; bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    check("rst_mid_wr_active", 32'(bus.dm_mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wr_drop", 32'(bus.dm_mem_write), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_addr", bus.dm_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.dm_mem_read || bus.dm_mem_write) seen++;
    end
    check("rst_mid_quiet", 32'(seen), 32'd0);
    check("rst_mid_mem", mem[2], ref_mem[2]);

    // req held high for three back-to-back loads
    model(1'b0, SZ_HALF, 1'b0, 32'h10001002, 32'h0, b_lat, b_ld, b_mis, b_rng, b_nrd, b_nwr, b_wd);
    @(negedge clk);
    bus.is_store = 1'b0; bus.size = SZ_HALF; bus.is_unsigned = 1'b0;
    bus.addr = 32'h10001002; bus.req = 1'b1;
    done_bits = '0; busy_bits = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 8) bus.req = 1'b0;
      done_bits[k] = bus.done;
      busy_bits[k] = bus.busy;
      if (bus.done) check("b2b_load", bus.load_data, b_ld);
    end
    check("b2b_done_pattern", 32'(done_bits), 32'(9'b010_010_010));
    check("b2b_busy_pattern", 32'(busy_bits), 32'(9'b011_011_011));
    @(negedge clk);
    check("b2b_stop", 32'(bus.busy), 32'd0);

    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      a = BASE - $urandom_range(1, 16);
      else if (r == 1) a = BASE + 32'd64 + $urandom_range(0, 16);
      else if (r == 2) a = 32'hFFFFFFFC + $urandom_range(0, 3);
      else             a = BASE + $urandom_range(0, 63);
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      access(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom), ld, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
